// File: rtl/spi_slave_ctrl_fsm.sv
// rtl/spi_slave_ctrl_fsm.sv - SPI slave protocol sequencer (command, address, dummy, data phases)
module spi_slave_ctrl_fsm #(
    parameter logic [7:0] DUMMY_RST = 8'd32,
    parameter logic [7:0] REG0_RST  = 8'h00
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic        cs,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic [5:0]  rx_counter,
    output logic        rx_counter_upd,
    output logic [31:0] tx_data,
    output logic [5:0]  tx_counter,
    output logic        tx_valid,
    input  logic        tx_done,
    output logic [7:0]  cmd,
    input  logic        get_addr,
    input  logic        get_data,
    input  logic        send_data,
    input  logic        enable_cont,
    input  logic        enable_regs,
    input  logic        wait_dummy,
    input  logic        error,
    input  logic [1:0]  reg_sel,
    output logic [31:0] addr,
    output logic        addr_valid,
    output logic [31:0] wr_data,
    output logic        wr_valid,
    input  logic [31:0] rd_data,
    input  logic        rd_valid,
    output logic        rd_ready,
    output logic [7:0]  reg0,
    output logic [7:0]  reg1
);

    // ST_CMD_DEC is the one-cycle decode step after the command byte lands,
    // giving the combinational decoder a full cycle on the registered cmd.
    typedef enum logic [2:0] {
        ST_CMD      = 3'd0,
        ST_CMD_DEC  = 3'd1,
        ST_ADDR     = 3'd2,
        ST_DUMMY    = 3'd3,
        ST_DATA_RX  = 3'd4,
        ST_DATA_TX  = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_cmd;
    logic [31:0] r_addr;
    logic        r_addr_valid;
    logic [31:0] r_wr_data;
    logic        r_wr_valid;
    logic [7:0]  r_reg0;
    logic [7:0]  r_reg1;
    logic [5:0]  r_rx_counter;
    logic        r_rx_counter_upd;
    logic        r_cs_d;
    logic [31:0] r_tx_data;
    logic [5:0]  r_tx_counter;
    logic        r_tx_busy;

    logic [5:0]  w_rx_cnt_nxt;
    logic        w_rx_upd;
    logic [5:0]  w_dummy_cnt;
    logic [7:0]  w_reg_rd;
    logic        w_tx_fire;
    logic        w_rd_pop;
    logic [31:0] w_tx_word;
    logic [5:0]  w_tx_cnt;

    // Dummy bit count minus one; values above 64 clamp to the 6-bit maximum.
    // reg1==64 wraps [5:0] to 0, and 0-1 gives 63 as wanted.
    assign w_dummy_cnt = (r_reg1 > 8'd64) ? 6'd63 : (r_reg1[5:0] - 6'd1);

    assign w_reg_rd = (reg_sel == 2'd0) ? r_reg0 :
                      (reg_sel == 2'd1) ? r_reg1 : 8'h00;

    assign w_tx_word = enable_regs ? {24'h0, w_reg_rd} : rd_data;
    assign w_tx_cnt  = enable_regs ? 6'd7 : 6'd31;

    // Next-state, tx/rd handshake and rx_counter target selection
    always_comb begin
        w_state_nxt  = r_state;
        w_tx_fire    = 1'b0;
        w_rd_pop     = 1'b0;
        w_rx_cnt_nxt = r_rx_counter;
        w_rx_upd     = 1'b0;

        case (r_state)
            ST_CMD: begin
                if (rx_valid) begin
                    w_state_nxt = ST_CMD_DEC;
                end
            end
            ST_CMD_DEC: begin
                if (error) begin
                    w_state_nxt = ST_DONE;
                end else if (get_addr) begin
                    w_state_nxt = ST_ADDR;
                end else if (get_data) begin
                    w_state_nxt = ST_DATA_RX;
                end else if (send_data) begin
                    w_state_nxt = ST_DATA_TX;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_ADDR: begin
                if (rx_valid) begin
                    if (wait_dummy && (r_reg1 != 8'd0)) begin
                        w_state_nxt = ST_DUMMY;
                    end else if (wait_dummy) begin
                        w_state_nxt = ST_DATA_TX;
                    end else if (get_data) begin
                        w_state_nxt = ST_DATA_RX;
                    end else begin
                        w_state_nxt = ST_DATA_TX;
                    end
                end
            end
            ST_DUMMY: begin
                if (rx_valid) begin
                    w_state_nxt = ST_DATA_TX;
                end
            end
            ST_DATA_RX: begin
                if (rx_valid && enable_regs) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DATA_TX: begin
                if (!r_tx_busy) begin
                    if (enable_regs) begin
                        w_tx_fire = 1'b1;
                    end else if (rd_valid) begin
                        w_tx_fire = 1'b1;
                        w_rd_pop  = 1'b1;
                    end
                end else if (tx_done) begin
                    if (enable_regs || !enable_cont) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_CMD;
            end
        endcase

        // Chip-select high overrides everything: back to command phase.
        if (cs) begin
            w_state_nxt = ST_CMD;
            w_tx_fire   = 1'b0;
            w_rd_pop    = 1'b0;
        end

        case (w_state_nxt)
            ST_CMD, ST_CMD_DEC: w_rx_cnt_nxt = 6'd7;
            ST_ADDR:            w_rx_cnt_nxt = 6'd31;
            ST_DUMMY:           w_rx_cnt_nxt = w_dummy_cnt;
            ST_DATA_RX:         w_rx_cnt_nxt = enable_regs ? 6'd7 : 6'd31;
            default:            w_rx_cnt_nxt = r_rx_counter;
        endcase

        // Abort always re-announces the counter once on the cs rising edge;
        // otherwise announce only on a state entry that changes it.
        if (cs) begin
            w_rx_upd = !r_cs_d;
        end else begin
            w_rx_upd = (w_state_nxt != r_state) && (w_rx_cnt_nxt != r_rx_counter);
        end
    end

    // State register
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state <= ST_CMD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // rx unit length register and its update strobe
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_rx_counter     <= 6'd7;
            r_rx_counter_upd <= 1'b0;
            r_cs_d           <= 1'b1;
        end else begin
            r_rx_counter     <= w_rx_cnt_nxt;
            r_rx_counter_upd <= w_rx_upd;
            r_cs_d           <= cs;
        end
    end

    // tx unit bookkeeping: last loaded word/length and in-flight flag
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_tx_data    <= 32'h0;
            r_tx_counter <= 6'd7;
            r_tx_busy    <= 1'b0;
        end else begin
            if (w_tx_fire) begin
                r_tx_data    <= w_tx_word;
                r_tx_counter <= w_tx_cnt;
            end
            if (cs || (r_state != ST_DATA_TX)) begin
                r_tx_busy <= 1'b0;
            end else if (w_tx_fire) begin
                r_tx_busy <= 1'b1;
            end else if (tx_done) begin
                r_tx_busy <= 1'b0;
            end
        end
    end

    // Command, address, memory write word and slave register capture
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_cmd        <= 8'h00;
            r_addr       <= 32'h0;
            r_addr_valid <= 1'b0;
            r_wr_data    <= 32'h0;
            r_wr_valid   <= 1'b0;
            r_reg0       <= REG0_RST;
            r_reg1       <= DUMMY_RST;
        end else begin
            r_addr_valid <= 1'b0;
            r_wr_valid   <= 1'b0;
            if (!cs) begin
                case (r_state)
                    ST_CMD: begin
                        if (rx_valid) begin
                            r_cmd <= rx_data[7:0];
                        end
                    end
                    ST_ADDR: begin
                        if (rx_valid) begin
                            r_addr       <= rx_data;
                            r_addr_valid <= 1'b1;
                        end
                    end
                    ST_DATA_RX: begin
                        if (rx_valid) begin
                            if (enable_regs) begin
                                if (reg_sel == 2'd0) begin
                                    r_reg0 <= rx_data[7:0];
                                end else if (reg_sel == 2'd1) begin
                                    r_reg1 <= rx_data[7:0];
                                end
                            end else begin
                                r_wr_data  <= rx_data;
                                r_wr_valid <= 1'b1;
                                if (enable_cont) begin
                                    r_addr <= r_addr + 32'd4;
                                end
                            end
                        end
                    end
                    ST_DATA_TX: begin
                        if (r_tx_busy && tx_done && !enable_regs && enable_cont) begin
                            r_addr <= r_addr + 32'd4;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign rx_counter     = r_rx_counter;
    assign rx_counter_upd = r_rx_counter_upd;
    assign tx_valid       = w_tx_fire;
    assign rd_ready       = w_rd_pop;
    assign tx_data        = w_tx_fire ? w_tx_word : r_tx_data;
    assign tx_counter     = w_tx_fire ? w_tx_cnt  : r_tx_counter;
    assign cmd            = r_cmd;
    assign addr           = r_addr;
    assign addr_valid     = r_addr_valid;
    assign wr_data        = r_wr_data;
    assign wr_valid       = r_wr_valid;
    assign reg0           = r_reg0;
    assign reg1           = r_reg1;

endmodule

// File: doc/spi_slave_ctrl_fsm.md
# spi_slave_ctrl_fsm

Protocol sequencer for the SPI slave, running in the SPI clock domain. Collects the command byte, drives it into the combinational command decoder, and uses the decoded flags to step through the transaction phases:
- address,
- dummy,
- data-in or data-out.

Owns the two 8-bit slave registers and hands memory words to the AXI-side FIFOs. Sits between the bit-level shift registers (rx/tx) and the command decoder / FIFOs.

## Interface
- DUMMY_RST, 8'd32, reset value of reg1 (dummy cycle count)
- REG0_RST, 8'h00, reset value of reg0
- sclk  in  1  SPI clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cs  in  1  chip select, active low, synchronous to sclk; high = abort/idle
- rx_data  in  32  received shift-register contents, valid with rx_valid
- rx_valid  in  1  one-cycle pulse: rx_counter+1 bits received
- rx_counter  out  6  bits-1 expected for the next rx unit
- rx_counter_upd  out  1  one-cycle pulse when rx_counter is loaded
- tx_data  out  32  word to shift out, MSB first
- tx_counter  out  6  bits-1 to send
- tx_valid  out  1  one-cycle pulse loading tx_data/tx_counter into the tx shifter
- tx_done  in  1  one-cycle pulse: last loaded tx unit fully shifted
- cmd  out  8  latched command byte, feeds the decoder
- get_addr, get_data, send_data, enable_cont, enable_regs, wait_dummy, error  in  1 each  decoder flags for cmd
- reg_sel  in  2  decoder register select
- addr  out  32  current memory address
- addr_valid  out  1  one-cycle pulse when addr is captured from the bus
- wr_data  out  32  memory write word
- wr_valid  out  1  one-cycle pulse per received memory word
- rd_data  in  32  read FIFO head
- rd_valid  in  1  read FIFO non-empty
- rd_ready  out  1  pop read FIFO (asserted only with rd_valid)
- reg0  out  8  slave register 0
- reg1  out  8  slave register 1 (dummy cycles)

## Operation
- States:
  - CMD
  - ADDR
  - DUMMY
  - DATA_RX
  - DATA_TX
  - DONE (ignore remaining bits until cs high)
- CMD: rx_counter=7.
  - On rx_valid: cmd<=rx_data[7:0].
  - Next state is chosen from the decoder flags of the newly latched cmd (evaluated the following cycle as DECODE sub-step, state CMD_DEC, counted within CMD).
  - error -> DONE; get_addr -> ADDR; get_data -> DATA_RX; send_data -> DATA_TX.
- ADDR: rx_counter=31.
  - On rx_valid: addr<=rx_data and addr_valid pulse.
  - Next state:
    - wait_dummy && reg1!=0 -> DUMMY
    - wait_dummy && reg1==0 -> DATA_TX
    - get_data -> DATA_RX
    - else DATA_TX
- DUMMY: rx_counter=reg1-1 (reg1 width-extended to 6 bits; reg1>64 saturates to 63). On rx_valid -> DATA_TX.
- DATA_RX:
  - enable_regs: rx_counter=7. On rx_valid, reg[reg_sel]<=rx_data[7:0], -> DONE. reg_sel 2/3: no write, -> DONE.
  - else: rx_counter=31. Each rx_valid: wr_data<=rx_data, wr_valid pulse. If enable_cont, addr<=addr+4 after the word (mod 2^32, wraps FFFF_FFFC->0000_0000); stay.
- DATA_TX:
  - enable_regs: tx_data={24'b0, reg[reg_sel]} (reg_sel 2/3 -> 0), tx_counter=7, tx_valid once, then on tx_done -> DONE.
  - mem: when rd_valid and no unit in flight, rd_ready and tx_valid pulse same cycle, tx_data=rd_data, tx_counter=31.
    - On tx_done: addr+=4 if enable_cont, next word; else -> DONE.
    - rd_valid low: wait, no tx_valid.
- rx_counter_upd pulses the cycle after each state entry that changes rx_counter.
- cs high (any state, any cycle): next state CMD, rx_counter=7, rx_counter_upd pulse, in-flight tx abandoned, no wr_valid/rd_ready that cycle. cmd, addr, reg0, reg1 keep their values.

## Timing
- Reset values:
  - state CMD
  - cmd 0, addr 0, reg0 REG0_RST, reg1 DUMMY_RST
  - rx_counter 7, tx_counter 7, tx_data 0
  - all pulses (rx_counter_upd, tx_valid, addr_valid, wr_valid, rd_ready) 0
- Decoder is combinational on registered cmd: flags are stable from the cycle after cmd latch. Branch decision is taken then (1 cycle).
- rx_valid -> addr_valid/wr_valid/register write: 1 cycle (registered).
- Register write is visible on reg0/reg1 the cycle after rx_valid.
- rd_valid high with unit idle -> rd_ready and tx_valid in the same cycle (combinational from rd_valid, gated by state). Next unit is not loaded before tx_done.
- rx_valid and cs high in the same cycle: cs wins, data discarded.
- rx_valid in DONE: ignored.
- rx_valid in DATA_TX: ignored.

## Test plan
- Reg write: cmd 0x01, then data 0xA5 -> reg0=0xA5 one cycle after rx_valid; state DONE. Same with 0x11 -> reg1=0xA5.
- Reg read: cmd 0x07 with reg1=0x20 -> one tx_valid with tx_data=0x0000_0020, tx_counter=7; after tx_done -> DONE.
- Mem write: cmd 0x02, addr 0x1000, three words -> addr_valid with 0x1000. wr_valid x3 with the three words; addr ends at 0x100C.
- Mem read with dummy: reg1=8, cmd 0x0B, addr 0xFFFF_FFFC -> rx_counter=7 in DUMMY, then DATA_TX.
  - rd_valid held low 5 cycles -> no tx_valid.
  - Then two words popped, one per tx_done; addr wraps to 0x0000_0004.
- Error cmd 0x33 -> DONE, no wr_valid/tx_valid. cs high -> CMD, rx_counter=7 with upd pulse.
- Abort: cs high mid address (rx_valid coincident) -> no addr_valid, state CMD. Next cmd 0x05 proceeds normally.
